// File: rtl/uart_tx_ctl_if.sv
// uart_tx_ctl_if: byte-request and serial-output signals of the UART transmitter.
//   TX_VALID  requester -> tx  request to send TX_DATA
//   TX_DATA   requester -> tx  byte to send, sampled only when the request is accepted
//   TX_RDY    tx -> requester  1 = idle and able to accept a byte
//   TXD       tx -> line       serial output, idles high
//   TX_DONE   tx -> requester  one-cycle pulse when the final stop bit completes
// master modport: the side that issues bytes; slave modport: the transmitter.
interface uart_tx_ctl_if;
  logic       TX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_RDY;
  logic       TXD;
  logic       TX_DONE;

  modport master (output TX_VALID, output TX_DATA,
                  input  TX_RDY, input TXD, input TX_DONE);
  modport slave  (input  TX_VALID, input TX_DATA,
                  output TX_RDY, output TXD, output TX_DONE);
endinterface

// File: rtl/uart_tx_ctl.sv
// uart_tx_ctl: UART transmitter, one byte per accepted request.
// Frame: start '0', 8 data bits LSB first, optional even parity (^data),
// then STOP_BITS stop bits '1'. Each line bit lasts 16 baud ticks, one tick
// every DIV = CLK_FREQ/BAUD_RATE/16 clocks.
// Ports:
//   CLK  system clock, all logic on posedge
//   RST  asynchronous active-low reset
//   bus  uart_tx_ctl_if.slave (TX_VALID, TX_DATA in; TX_RDY, TXD, TX_DONE out)
module uart_tx_ctl #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_ctl_if.slave bus
);
  localparam int DIV   = CLK_FREQ / BAUD_RATE / 16;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;

  logic accept;
  logic tick;
  logic bit_end;
  logic last_stop;

  assign accept  = (state_q == IDLE) && bus.TX_VALID;
  // The divider only runs outside IDLE, so the first tick of a frame lands
  // exactly DIV clocks after the accept edge.
  assign tick    = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
  assign bit_end = tick && (tick_cnt_q == 4'd15);
  // With two stop bits the first one ends with stop_cnt_q = 0, the second with 1.
  assign last_stop = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;

  // State register and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && (bit_cnt_q == 3'd7))
                state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. TXD is computed one edge ahead so the line
  // comes straight from a flop and changes only on accept or a bit boundary.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    if (state_q == IDLE || tick) div_cnt_d = '0;
    else                         div_cnt_d = div_cnt_q + DIV_W'(1);

    // 4-bit tick counter wraps 15 -> 0 at every bit boundary.
    if (state_q == IDLE) tick_cnt_d = '0;
    else if (tick)       tick_cnt_d = tick_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        txd_d      = 1'b1;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (accept) begin
          shift_d  = bus.TX_DATA;
          parity_d = ^bus.TX_DATA;
          txd_d    = 1'b0;
        end
      end
      START: if (bit_end) txd_d = shift_q[0];
      DATA: if (bit_end) begin
        // Counter wraps 7 -> 0 on the last data bit, leaving it clean for the next frame.
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = {1'b0, shift_q[7:1]};
        if (bit_cnt_q == 3'd7) txd_d = (PARITY_EN != 0) ? parity_q : 1'b1;
        else                   txd_d = shift_q[1];
      end
      PARITY: if (bit_end) txd_d = 1'b1;
      STOP: if (bit_end) begin
        txd_d = 1'b1;
        if (last_stop) done_d = 1'b1;
        else           stop_cnt_d = 1'b1;
      end
      default: txd_d = 1'b1;
    endcase
  end

  // TX_RDY follows the registered state, so it drops on the accept edge and
  // rises on the same edge that raises TX_DONE.
  assign bus.TX_RDY  = (state_q == IDLE);
  assign bus.TXD     = txd_q;
  assign bus.TX_DONE = done_q;
endmodule

// File: tb/tb_uart_tx_ctl.sv
// tb_uart_tx_ctl: scoreboard bench for uart_tx_ctl.
// Instance 0: DIV=10, parity on, 1 stop bit. Instance 1: DIV=10, parity off, 2 stop bits.
// Stimulus pushes the expected frame into a per-instance queue; a monitor per
// instance samples TXD at both ends of every bit and compares at each TX_DONE.
module tb_uart_tx_ctl;
  localparam int BIT = 160;        // 16 * DIV clocks per line bit
  localparam int NB  = 11;         // line bits per frame in both configurations
  localparam int FRAME = BIT * NB; // 1760

  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] frame;  // bit k = expected TXD during line bit k
    bit            chk_gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data [2];
  logic [1:0] txd_w, rdy_w, done_w;
  int         done_cnt [2];
  exp_t       exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int PEN = (gi == 0) ? 1 : 0;
    localparam int SB  = (gi == 0) ? 1 : 2;

    uart_tx_ctl_if u_if ();

    assign u_if.TX_VALID = tx_valid[gi];
    assign u_if.TX_DATA  = tx_data[gi];
    assign txd_w[gi]     = u_if.TXD;
    assign rdy_w[gi]     = u_if.TX_RDY;
    assign done_w[gi]    = u_if.TX_DONE;

    uart_tx_ctl #(
      .CLK_FREQ (1600),
      .BAUD_RATE(10),
      .PARITY_EN(PEN),
      .STOP_BITS(SB)
    ) u_dut (
      .CLK(clk),
      .RST(rst_n),
      .bus(u_if)
    );

    logic [NB-1:0] first_q, last_q;
    int   acc_cyc = 0;
    int   done_cyc = -100000;
    int   cur_gap = 0;
    bit   active = 0;
    bit   rdy_seen = 0;
    int   el;
    exp_t e;

    always @(negedge clk) begin
      if (!rst_n) begin
        active = 0;
      end else begin
        if (done_w[gi]) begin
          done_cnt[gi]++;
          done_cyc = cyc;
          if (exp_q[gi].size() == 0) begin
            chk($sformatf("unexpected_done_%0d", gi), 1'b0, 1, 0);
          end else begin
            e = exp_q[gi].pop_front();
            chk($sformatf("frame_start_samples_%0d", gi), first_q == e.frame, 32'(first_q), 32'(e.frame));
            chk($sformatf("frame_end_samples_%0d", gi), last_q == e.frame, 32'(last_q), 32'(e.frame));
            chk($sformatf("done_latency_%0d", gi), (cyc - acc_cyc) == FRAME, cyc - acc_cyc, FRAME);
            chk($sformatf("rdy_low_in_frame_%0d", gi), !rdy_seen, 32'(rdy_seen), 0);
            if (e.chk_gap)
              chk($sformatf("b2b_start_gap_%0d", gi), cur_gap == 1, cur_gap, 1);
            $display("inst%0d frame data=%02h line=%03h latency=%0d", gi, e.data, first_q, cyc - acc_cyc);
          end
          active = 0;
        end else if (active) begin
          el = cyc - acc_cyc;
          if (el < FRAME) begin
            if (el % BIT == 0)       first_q[el / BIT] = txd_w[gi];
            if (el % BIT == BIT - 1) last_q[el / BIT]  = txd_w[gi];
            if (rdy_w[gi]) rdy_seen = 1;
          end
        end
        // Inputs are stable until the next posedge, so this predicts the accept edge.
        if (tx_valid[gi] && rdy_w[gi]) begin
          active   = 1;
          acc_cyc  = cyc + 1;
          cur_gap  = acc_cyc - done_cyc;
          rdy_seen = 0;
          first_q  = '1;
          last_q   = '1;
        end
      end
    end
  end

  task automatic push(input int inst, input logic [7:0] d, input logic par, input bit gap);
    exp_t e;
    e.data    = d;
    e.frame   = (inst == 0) ? {1'b1, par, d, 1'b0} : {2'b11, d, 1'b0};
    e.chk_gap = gap;
    exp_q[inst].push_back(e);
  endtask

  // Waits for TX_RDY, presents the byte for one cycle, then scrambles TX_DATA.
  task automatic send(input int inst, input logic [7:0] d, input logic par);
    int b;
    push(inst, d, par, 1'b0);
    b = 0;
    while (!rdy_w[inst] && b < 4000) begin
      @(posedge clk); #1; b++;
    end
    if (!rdy_w[inst]) chk("rdy_timeout", 1'b0, 0, 1);
    tx_data[inst]  = d;
    tx_valid[inst] = 1'b1;
    @(posedge clk); #1;
    tx_valid[inst] = 1'b0;
    tx_data[inst]  = ~d;
  endtask

  task automatic wait_done(input int inst, input int target, input int budget);
    int b;
    b = 0;
    while (done_cnt[inst] < target && b < budget) begin
      @(posedge clk); #1; b++;
    end
    if (done_cnt[inst] < target) chk("done_timeout", 1'b0, done_cnt[inst], target);
  endtask

  initial begin
    int base;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    done_cnt[0] = 0;
    done_cnt[1] = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_txd", txd_w[i] == 1'b1, 32'(txd_w[i]), 1);
      chk("reset_rdy", rdy_w[i] == 1'b1, 32'(rdy_w[i]), 1);
      chk("reset_done", done_w[i] == 1'b0, 32'(done_w[i]), 0);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic frames with parity: 0x41 (parity 0), 0x07 (parity 1), 0x00 (parity 0).
    send(0, 8'h41, 1'b0); wait_done(0, 1, 2000);
    send(0, 8'h07, 1'b1); wait_done(0, 2, 2000);
    send(0, 8'h00, 1'b0); wait_done(0, 3, 2000);

    // No parity, two stop bits.
    send(1, 8'hA5, 1'b0); wait_done(1, 1, 2000);

    // Back-to-back with TX_VALID held; second start must follow TX_DONE by 1 clock.
    push(0, 8'h55, 1'b0, 1'b0);
    push(0, 8'hAA, 1'b0, 1'b1);
    tx_data[0]  = 8'h55;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_data[0]  = 8'hAA;
    wait_done(0, 4, 2000);
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (200) @(posedge clk);
      #1;
      tx_data[0] = 8'($urandom);
    end
    wait_done(0, 5, 2000);

    // TX_VALID pulsed during DATA of an in-flight frame must be ignored.
    send(0, 8'h07, 1'b1);
    base = done_cnt[0];
    repeat (4 * BIT) @(posedge clk);
    #1;
    tx_data[0]  = 8'hFF;
    tx_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    wait_done(0, base + 1, 2000);
    repeat (100) @(posedge clk);
    #1;
    chk("ignored_valid_done_count", done_cnt[0] == base + 1, done_cnt[0], base + 1);

    // Asynchronous reset during a data bit of 0x00.
    send(0, 8'h00, 1'b0);
    base = done_cnt[0];
    repeat (3 * BIT + 37) @(posedge clk);
    #1;
    chk("pre_reset_txd_low", txd_w[0] == 1'b0, 32'(txd_w[0]), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd_w[0] == 1'b1, 32'(txd_w[0]), 1);
    chk("async_reset_rdy", rdy_w[0] == 1'b1, 32'(rdy_w[0]), 1);
    chk("async_reset_done", done_w[0] == 1'b0, 32'(done_w[0]), 0);
    void'(exp_q[0].pop_back());
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_no_done", done_cnt[0] == base, done_cnt[0], base);
    send(0, 8'h41, 1'b0);
    wait_done(0, base + 1, 2000);

    repeat (50) @(posedge clk);
    #1;
    chk("queue0_drained", exp_q[0].size() == 0, exp_q[0].size(), 0);
    chk("queue1_drained", exp_q[1].size() == 0, exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
